// File: rtl/lc3_mem_ctrl_if.sv
// CPU-side request/response bundle of the LC-3 memory sequencer.
// The control unit is the master; the sequencer is the slave.
interface lc3_mem_ctrl_if;
  logic        Mem_OE;
  logic        Mem_WE;
  logic [15:0] MAR;
  logic [15:0] MDR_In;
  logic [15:0] Data_to_CPU;
  logic        Mem_Ready;

  modport master (
    output Mem_OE, Mem_WE, MAR, MDR_In,
    input  Data_to_CPU, Mem_Ready
  );

  modport slave (
    input  Mem_OE, Mem_WE, MAR, MDR_In,
    output Data_to_CPU, Mem_Ready
  );
endinterface

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory sequencer: level requests to timed async-SRAM strobes,
// plus the memory-mapped switch / hex-display I/O location.
module lc3_mem_ctrl #(
  parameter int          READ_WAIT  = 2,
  parameter int          WRITE_WAIT = 2,
  parameter logic [15:0] IO_ADDR    = 16'hFFFF
) (
  input  logic               Clk,
  input  logic               Reset,
  lc3_mem_ctrl_if.slave      cpu,
  input  logic [15:0]        Switches,
  output logic [15:0]        HEX_Data,
  output logic [19:0]        SRAM_ADDR,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_WE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic [15:0]        SRAM_DQ_out,
  output logic               SRAM_DQ_oe,
  input  logic [15:0]        SRAM_DQ_in
);

  typedef enum logic [2:0] {
    IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE, RELEASE
  } state_e;

  localparam logic [7:0] RD_LAST = 8'(READ_WAIT - 1);
  localparam logic [7:0] WR_LAST = 8'(WRITE_WAIT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] hex_q, hex_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      hex_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      hex_q   <= hex_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    hex_d   = hex_q;
    case (state_q)
      IDLE: begin
        if (cpu.Mem_OE || cpu.Mem_WE) begin
          addr_d  = cpu.MAR;
          wdata_d = cpu.MDR_In;
          if (cpu.MAR == IO_ADDR) begin
            state_d = DONE;
            if (cpu.Mem_WE) hex_d   = cpu.MDR_In;
            else            rdata_d = Switches;
          end else begin
            state_d = cpu.Mem_WE ? WR_SETUP : RD;
          end
        end
      end
      RD: begin
        if (cnt_q == RD_LAST) begin
          cnt_d   = '0;
          rdata_d = SRAM_DQ_in;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WR_SETUP: state_d = WR_PULSE;
      WR_PULSE: begin
        if (cnt_q == WR_LAST) begin
          cnt_d   = '0;
          state_d = WR_HOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WR_HOLD: state_d = DONE;
      DONE:    state_d = RELEASE;
      RELEASE: begin
        // Wait for the request to drop so one held request = one access.
        if (!cpu.Mem_OE && !cpu.Mem_WE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    SRAM_CE_N     = 1'b1;
    SRAM_OE_N     = 1'b1;
    SRAM_WE_N     = 1'b1;
    SRAM_DQ_oe    = 1'b0;
    cpu.Mem_Ready = 1'b0;
    case (state_q)
      RD: begin
        SRAM_CE_N = 1'b0;
        SRAM_OE_N = 1'b0;
      end
      WR_SETUP, WR_HOLD: begin
        SRAM_CE_N  = 1'b0;
        SRAM_DQ_oe = 1'b1;
      end
      WR_PULSE: begin
        SRAM_CE_N  = 1'b0;
        SRAM_WE_N  = 1'b0;
        SRAM_DQ_oe = 1'b1;
      end
      DONE:    cpu.Mem_Ready = 1'b1;
      default: ;
    endcase
  end

  assign SRAM_UB_N       = SRAM_CE_N;
  assign SRAM_LB_N       = SRAM_CE_N;
  assign SRAM_ADDR       = {4'b0, addr_q};
  assign SRAM_DQ_out     = wdata_q;
  assign cpu.Data_to_CPU = rdata_q;
  assign HEX_Data        = hex_q;

endmodule
